jtag_multi_master: RTL and testbench

Parametrised multi-channel JTAG shift engine for the tester system. It generalises the fixed pair of JTAG ports to `g_channels` independently muxed TAPs, adds a programmable TCK divider, TMS-stream mode, TDO capture and a completion interrupt. It sits on the 8-bit I/O bus as a slave and is driven byte-wise by the soft CPU.

---
 rtl/jtag_multi_master.sv | 206 ++++++++++++++++++++
 tb/tb_jtag_multi_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_multi_master.sv
// Byte-wide I/O slave that drives g_channels muxed JTAG TAPs: one CMD shifts up to 8 bits at half-period DIV+1; ack/rdata one cycle after strobe.
// No backpressure: accesses always ack next cycle, busy-time writes to CHAN/DIV/CMD are dropped; JTAG_MULTI_IRQ_EN enables the level irq.
module jtag_multi_master #(
  parameter int g_channels = 2,
  parameter int g_div_bits = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            io_address,
  input  logic                  io_read,
  input  logic                  io_write,
  input  logic [7:0]            io_wdata,
  output logic [7:0]            io_rdata,
  output logic                  io_ack,
  output logic                  irq,
  output logic [g_channels-1:0] jtag_tck,
  output logic [g_channels-1:0] jtag_tms,
  output logic [g_channels-1:0] jtag_tdi,
  input  logic [g_channels-1:0] jtag_tdo
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  state_t                state_q, state_d;
  logic [2:0]            chan_q, chan_d;
  logic [g_div_bits-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [7:0]            data_q, data_d, sh_q, sh_d, tdo_q, tdo_d;
  logic [2:0]            nbits_q, nbits_d, bidx_q, bidx_d;
  logic                  tlast_q, tlast_d, tmode_q, tmode_d;
  logic                  done_q, done_d, ack_q, ack_d, clr_q, clr_d;
  logic [7:0]            rdata_q, rdata_d;
  logic [g_channels-1:0] tms_q, tms_d, tdi_q, tdi_d;
  logic                  busy, tdo_sel, drv_en, drv_bit, drv_last;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sh_d    = sh_q;
    tdo_d   = tdo_q;
    nbits_d = nbits_q;
    bidx_d  = bidx_q;
    tlast_d = tlast_q;
    tmode_d = tmode_q;
    done_d  = done_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    ack_d   = io_read | io_write;
    rdata_d = '0;
    clr_d   = 1'b0;
    drv_en  = 1'b0;
    drv_bit = 1'b0;
    drv_last = 1'b0;
    busy    = (state_q != S_IDLE);
    tdo_sel = 1'b0;
    for (int c = 0; c < g_channels; c++) begin
      if (chan_q == 3'(c)) tdo_sel = jtag_tdo[c];
    end

    if (io_read && !io_write) begin
      case (io_address)
        3'd0: rdata_d = {5'd0, chan_q};
        3'd1: rdata_d = 8'(div_q);
        3'd4: begin
          rdata_d = tdo_q;
          clr_d   = 1'b1;
        end
        3'd5: rdata_d = {6'd0, done_q, busy};
        default: rdata_d = '0;
      endcase
    end

    // DONE drops at the end of the TDO read's ack cycle so irq falls one cycle after the ack
    if (ack_q && clr_q) done_d = 1'b0;

    if (io_write) begin
      case (io_address)
        3'd0: if (!busy && ({24'd0, io_wdata} < g_channels)) chan_d = io_wdata[2:0];
        3'd1: if (!busy) div_d = io_wdata[g_div_bits-1:0];
        3'd2: data_d = io_wdata;
        3'd3: if (!busy) begin
          state_d  = S_LOW;
          sh_d     = {1'b0, data_q[7:1]};
          nbits_d  = io_wdata[2:0];
          tlast_d  = io_wdata[3];
          tmode_d  = io_wdata[4];
          bidx_d   = '0;
          cnt_d    = '0;
          tdo_d    = '0;
          done_d   = 1'b0;
          drv_en   = 1'b1;
          drv_bit  = data_q[0];
          drv_last = (io_wdata[2:0] == 3'd0);
        end
        default: ;
      endcase
    end

    case (state_q)
      S_LOW: begin
        if (cnt_q == div_q) begin
          cnt_d         = '0;
          state_d       = S_HIGH;
          tdo_d[bidx_q] = tdo_sel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (bidx_q == nbits_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_LOW;
            bidx_d   = bidx_q + 1'b1;
            sh_d     = sh_q >> 1;
            drv_en   = 1'b1;
            drv_bit  = sh_q[0];
            drv_last = ((bidx_q + 1'b1) == nbits_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Only the selected channel's pins change; others keep their last driven level
    if (drv_en) begin
      for (int c = 0; c < g_channels; c++) begin
        if (chan_q == 3'(c)) begin
          tms_d[c] = tmode_d ? drv_bit : (tlast_d & drv_last);
          tdi_d[c] = tmode_d ? 1'b0 : drv_bit;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sh_q    <= '0;
      tdo_q   <= '0;
      nbits_q <= '0;
      bidx_q  <= '0;
      tlast_q <= 1'b0;
      tmode_q <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      clr_q   <= 1'b0;
      rdata_q <= '0;
      tms_q   <= '1;
      tdi_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sh_q    <= sh_d;
      tdo_q   <= tdo_d;
      nbits_q <= nbits_d;
      bidx_q  <= bidx_d;
      tlast_q <= tlast_d;
      tmode_q <= tmode_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      clr_q   <= clr_d;
      rdata_q <= rdata_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  always_comb begin
    jtag_tck = '0;
    for (int c = 0; c < g_channels; c++) begin
      if (state_q == S_HIGH && chan_q == 3'(c)) jtag_tck[c] = 1'b1;
    end
  end

  assign jtag_tms = tms_q;
  assign jtag_tdi = tdi_q;
  assign io_ack   = ack_q;
  assign io_rdata = rdata_q;

`ifdef JTAG_MULTI_IRQ_EN
  logic irq_q;
  always_ff @(posedge clock) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= done_d;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_multi_master.sv
// Directed bench for jtag_multi_master: channel 1 TDO is looped back from its TDI.
module tb_jtag_multi_master;

`ifdef JTAG_MULTI_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] io_address = '0;
  logic       io_read = 1'b0;
  logic       io_write = 1'b0;
  logic [7:0] io_wdata = '0;
  logic [7:0] io_rdata;
  logic       io_ack;
  logic       irq;
  logic [1:0] jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;

  int vectors = 0;
  int miscompares = 0;

  assign jtag_tdo = jtag_tdi;

  always #5 clock = ~clock;

  jtag_multi_master #(.g_channels(2), .g_div_bits(8)) dut (
    .clock(clock), .reset(reset), .io_address(io_address), .io_read(io_read),
    .io_write(io_write), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
    .irq(irq), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_tdo(jtag_tdo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clock);
    io_address = a; io_wdata = d; io_write = 1'b1;
    @(negedge clock);
    io_write = 1'b0;
    check("wr_ack", io_ack, 1);
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clock);
    io_address = a; io_read = 1'b1;
    @(negedge clock);
    io_read = 1'b0;
    check("rd_ack", io_ack, 1);
    d = io_rdata;
  endtask

  // Follows one shift from the CMD ack cycle: TMS/TDI seen at each TCK rise, busy length, phase widths
  task automatic watch(input int ch, input int nbits, input int half,
                       output logic [7:0] tms_seq, output logic [7:0] tdi_seq,
                       output int busy, output int bad);
    int   pulses = 0;
    int   run = 0;
    int   last_hi = -1;
    logic prev = 1'b0;
    logic cur;
    logic [1:0] other;
    tms_seq = '0; tdi_seq = '0; busy = -1; bad = 0;
    for (int k = 0; k < 600; k++) begin
      cur = jtag_tck[ch];
      other = jtag_tck;
      other[ch] = 1'b0;
      if (other != 2'b00) bad++;
      if (cur != prev) begin
        if (run != half) bad++;
        run = 0;
      end
      if (cur && !prev) begin
        if (pulses < 8) begin
          tms_seq[pulses] = jtag_tms[ch];
          tdi_seq[pulses] = jtag_tdi[ch];
        end
        pulses++;
      end
      if (cur) last_hi = k;
      run++;
      prev = cur;
      if (!cur && pulses == nbits && last_hi >= 0) begin
        busy = last_hi + 1;
        break;
      end
      @(negedge clock);
    end
  endtask

  logic [7:0] rd, ts, ti;
  int         busy_c, bad_c, n, rises;
  logic       prv;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tck", jtag_tck, 2'b00);
    check("rst_tms", jtag_tms, 2'b11);
    check("rst_tdi", jtag_tdi, 2'b00);
    check("rst_ack", io_ack, 0);
    check("rst_rdata", io_rdata, 8'h00);
    check("rst_irq", irq, 0);
    reset = 1'b0;
    bus_rd(3'd5, rd); check("rst_status", rd, 8'h00);
    @(negedge clock);
    check("ack_one_cycle", io_ack, 0);
    check("rdata_idle", io_rdata, 8'h00);
    bus_rd(3'd0, rd); check("rst_chan", rd, 8'h00);
    bus_rd(3'd1, rd); check("rst_div", rd, 8'h00);

    // 8-bit loopback shift on channel 1, DIV=0
    bus_wr(3'd0, 8'h01);
    bus_wr(3'd1, 8'h00);
    bus_wr(3'd2, 8'hA5);
    bus_wr(3'd3, 8'h07);
    watch(1, 8, 1, ts, ti, busy_c, bad_c);
    check("t1_busy", busy_c, 16);
    check("t1_shape", bad_c, 0);
    check("t1_tms", ts, 8'h00);
    check("t1_tdi", ti, 8'hA5);
    check("t1_irq", irq, IRQ_ON);
    bus_rd(3'd5, rd); check("t1_done", rd, 8'h02);
    bus_rd(3'd4, rd); check("t1_tdo", rd, 8'hA5);
    check("t1_irq_ack", irq, IRQ_ON);
    @(negedge clock);
    check("t1_irq_clr", irq, 0);
    bus_rd(3'd5, rd); check("t1_done_clr", rd, 8'h00);

    // TMS stream mode, 5 bits, DIV=3
    bus_wr(3'd1, 8'h03);
    bus_wr(3'd2, 8'h1F);
    bus_wr(3'd3, 8'h14);
    watch(1, 5, 4, ts, ti, busy_c, bad_c);
    check("t2_busy", busy_c, 40);
    check("t2_shape", bad_c, 0);
    check("t2_tms", ts, 8'h1F);
    check("t2_tdi", ti, 8'h00);
    bus_rd(3'd4, rd); check("t2_tdo", rd, 8'h00);

    // 3 bits with tms_last; TDO bits above the count stay 0
    bus_wr(3'd2, 8'hFE);
    bus_wr(3'd3, 8'h0A);
    watch(1, 3, 4, ts, ti, busy_c, bad_c);
    check("t3_busy", busy_c, 24);
    check("t3_shape", bad_c, 0);
    check("t3_tms", ts, 8'h04);
    check("t3_tdi", ti, 8'h06);
    bus_rd(3'd4, rd); check("t3_tdo", rd, 8'h06);
    check("hold_tms", jtag_tms, 2'b11);
    check("hold_tdi", jtag_tdi, 2'b10);

    // Writes while busy are acked but dropped
    bus_wr(3'd1, 8'h00);
    bus_wr(3'd2, 8'h3C);
    bus_wr(3'd3, 8'h07);
    fork
      watch(1, 8, 1, ts, ti, busy_c, bad_c);
      begin
        bus_wr(3'd0, 8'h00);
        bus_wr(3'd1, 8'h09);
        bus_wr(3'd3, 8'h07);
      end
    join
    check("t4_busy", busy_c, 16);
    check("t4_shape", bad_c, 0);
    check("t4_tdi", ti, 8'h3C);
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (jtag_tck != 2'b00) n++;
    end
    check("t4_no_restart", n, 0);
    bus_rd(3'd5, rd); check("t4_done", rd, 8'h02);
    bus_rd(3'd4, rd); check("t4_tdo", rd, 8'h3C);
    bus_rd(3'd0, rd); check("t4_chan", rd, 8'h01);
    bus_rd(3'd1, rd); check("t4_div", rd, 8'h00);

    // Out-of-range channel, unused address, read+write collision
    bus_wr(3'd0, 8'h05);
    bus_rd(3'd0, rd); check("t5_chan", rd, 8'h01);
    bus_wr(3'd6, 8'h55);
    bus_rd(3'd6, rd); check("t5_addr6", rd, 8'h00);
    @(negedge clock);
    io_address = 3'd0; io_wdata = 8'h00; io_read = 1'b1; io_write = 1'b1;
    @(negedge clock);
    io_read = 1'b0; io_write = 1'b0;
    check("rw_ack", io_ack, 1);
    check("rw_rdata", io_rdata, 8'h00);
    bus_rd(3'd0, rd); check("rw_is_write", rd, 8'h00);

    // Reset in the middle of bit 3 of an 8-bit shift
    bus_wr(3'd0, 8'h01);
    bus_wr(3'd1, 8'h03);
    bus_wr(3'd2, 8'hFF);
    bus_wr(3'd3, 8'h07);
    bus_rd(3'd5, rd); check("t6_busy", rd, 8'h01);
    rises = 0;
    prv = jtag_tck[1];
    for (int k = 0; k < 200 && rises < 3; k++) begin
      @(negedge clock);
      if (jtag_tck[1] && !prv) rises++;
      prv = jtag_tck[1];
    end
    check("t6_reach_bit3", rises, 3);
    reset = 1'b1;
    @(negedge clock);
    check("t6_tck", jtag_tck, 2'b00);
    check("t6_tms", jtag_tms, 2'b11);
    check("t6_tdi", jtag_tdi, 2'b00);
    check("t6_irq", irq, 0);
    reset = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (jtag_tck != 2'b00) n++;
    end
    check("t6_no_tck", n, 0);
    bus_rd(3'd5, rd); check("t6_status", rd, 8'h00);
    bus_rd(3'd0, rd); check("t6_chan", rd, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
